// File: rtl/bbc_wrbuf_m.sv
// Posted-write buffer: queues CPU lomem writes and replays them on the BBC host bus,
// one write per 2 MHz slot, with 1 MHz-region writes stretched across two slots.
module bbc_wrbuf_m #(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] STRETCH_LO = 16'hFC00,
  parameter logic [15:0] STRETCH_HI = 16'hFEFF
) (
  input  logic        bbc_ck8,
  input  logic        resetb,
  input  logic        bbc_ck2_phi0,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_full,
  output logic        wr_empty,
  output logic        wr_overflow,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data,
  output logic        bus_data_oe,
  output logic        bus_rnw,
  output logic        bus_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_WAIT, S_HOLD} state_t;

  state_t                     state_q, state_d;
  logic [DEPTH-1:0][15:0]     addr_mem_q, addr_mem_d;
  logic [DEPTH-1:0][7:0]      data_mem_q, data_mem_d;
  logic [DEPTH-1:0]           str_mem_q, str_mem_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]                count_q, count_d;
  logic                       phi0_q, phi0_d;
  logic [1:0]                 slots_q, slots_d;
  logic [15:0]                addr_q, addr_d;
  logic [7:0]                 data_q, data_d;
  logic                       ovf_q, ovf_d;

  logic rise, fall, pop, push_ok, start;

  assign rise    = bbc_ck2_phi0 & ~phi0_q;
  assign fall    = ~bbc_ck2_phi0 & phi0_q;
  assign pop     = (state_q == S_HOLD);
  assign push_ok = wr_req & ((count_q < DEPTH_C) | pop);
  assign start   = (state_q == S_IDLE) & rise & (count_q != '0);

  always_ff @(posedge bbc_ck8 or negedge resetb) begin
    if (!resetb) begin
      state_q    <= S_IDLE;
      addr_mem_q <= '0;
      data_mem_q <= '0;
      str_mem_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      phi0_q     <= 1'b0;
      slots_q    <= 2'd0;
      addr_q     <= 16'h8000;
      data_q     <= 8'h00;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_mem_q <= addr_mem_d;
      data_mem_q <= data_mem_d;
      str_mem_q  <= str_mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      phi0_q     <= phi0_d;
      slots_q    <= slots_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_DRIVE;
      S_DRIVE: if (fall) state_d = (slots_q == 2'd1) ? S_HOLD : S_WAIT;
      S_WAIT:  if (rise) state_d = S_DRIVE;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_mem_d = addr_mem_q;
    data_mem_d = data_mem_q;
    str_mem_d  = str_mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    phi0_d     = bbc_ck2_phi0;
    slots_d    = slots_q;
    addr_d     = addr_q;
    data_d     = data_q;
    ovf_d      = ovf_q | (wr_req & ~push_ok);
    if (push_ok) begin
      addr_mem_d[wr_ptr_q] = wr_addr;
      data_mem_d[wr_ptr_q] = wr_data;
      str_mem_d[wr_ptr_q]  = (wr_addr >= STRETCH_LO) && (wr_addr <= STRETCH_HI);
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    // The head entry stays in the FIFO until HOLD so wr_full/count cover the in-flight write.
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (start) begin
      addr_d  = addr_mem_q[rd_ptr_q];
      data_d  = data_mem_q[rd_ptr_q];
      slots_d = str_mem_q[rd_ptr_q] ? 2'd2 : 2'd1;
    end
    if ((state_q == S_DRIVE) && fall) slots_d = slots_q - 2'd1;
  end

  always_comb begin
    bus_addr    = addr_q;
    bus_data    = data_q;
    bus_rnw     = 1'b1;
    bus_data_oe = 1'b1;
    bus_busy    = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus_addr    = 16'h8000;
        bus_data    = 8'h00;
        bus_data_oe = 1'b0;
        bus_busy    = 1'b0;
      end
      S_DRIVE: bus_rnw = 1'b0;
      default: ;
    endcase
    wr_full     = (count_q == DEPTH_C);
    wr_empty    = (count_q == '0) && (state_q == S_IDLE);
    wr_overflow = ovf_q;
  end
endmodule

// File: tb/tb_bbc_wrbuf_m.sv
// Directed bench for bbc_wrbuf_m: phi0 runs 2 low / 2 high ck8 cycles from a free counter,
// host writes are logged at each rnw falling edge that starts from an idle bus.
module tb_bbc_wrbuf_m;
  logic        bbc_ck8 = 1'b0, resetb = 1'b0, bbc_ck2_phi0 = 1'b0, wr_req = 1'b0;
  logic [15:0] wr_addr = 16'h0;
  logic [7:0]  wr_data = 8'h0;
  logic        wr_full, wr_empty, wr_overflow, bus_data_oe, bus_rnw, bus_busy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data;

  int          checks = 0, errors = 0, cyc = 0;
  logic [1:0]  ph_cnt = 2'd0;
  logic        prev_rnw = 1'b1, prev_oe = 1'b0;
  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];
  int          log_cyc[$];
  int          base;

  bbc_wrbuf_m dut (
    .bbc_ck8(bbc_ck8), .resetb(resetb), .bbc_ck2_phi0(bbc_ck2_phi0),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_full(wr_full), .wr_empty(wr_empty), .wr_overflow(wr_overflow),
    .bus_addr(bus_addr), .bus_data(bus_data), .bus_data_oe(bus_data_oe),
    .bus_rnw(bus_rnw), .bus_busy(bus_busy)
  );

  always #5 bbc_ck8 = ~bbc_ck8;

  // phi0 is low while ph_cnt is 0/1 and high while 2/3
  always @(posedge bbc_ck8) begin
    #1;
    ph_cnt = ph_cnt + 2'd1;
    bbc_ck2_phi0 = ph_cnt[1];
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge bbc_ck8) begin
    if (resetb) begin
      if (!bus_rnw && prev_rnw && !prev_oe) begin
        log_addr.push_back(bus_addr);
        log_data.push_back(bus_data);
        log_cyc.push_back(cyc);
      end
      if (bus_data_oe) chk("oe_only_when_busy", bus_busy, 1);
    end
    prev_rnw = bus_rnw;
    prev_oe  = bus_data_oe;
  end

  task automatic nxt();
    @(posedge bbc_ck8);
    #2;
  endtask

  task automatic align(input logic [1:0] c);
    for (int i = 0; i < 4 && ph_cnt != c; i++) nxt();
  endtask

  task automatic chk_bus(input string tag, input logic [15:0] a, input logic [7:0] d,
                         input logic rnw, input logic oe);
    @(negedge bbc_ck8);
    chk({tag, "_addr"}, bus_addr, a);
    chk({tag, "_data"}, bus_data, d);
    chk({tag, "_rnw"}, bus_rnw, rnw);
    chk({tag, "_oe"}, bus_data_oe, oe);
  endtask

  task automatic wait_empty(input int lim);
    int n;
    n = 0;
    while (!wr_empty && n < lim) begin
      nxt();
      n++;
    end
    chk("drain_timeout", n < lim, 1);
  endtask

  // stretched write followed by a normal one; {addr, data, rnw, oe} per cycle from c=1
  logic [25:0] str_tab [13] = '{
    {16'h8000, 8'h00, 1'b1, 1'b0}, {16'h8000, 8'h00, 1'b1, 1'b0},
    {16'hFE40, 8'h0F, 1'b0, 1'b1}, {16'hFE40, 8'h0F, 1'b0, 1'b1},
    {16'hFE40, 8'h0F, 1'b1, 1'b1}, {16'hFE40, 8'h0F, 1'b1, 1'b1},
    {16'hFE40, 8'h0F, 1'b0, 1'b1}, {16'hFE40, 8'h0F, 1'b0, 1'b1},
    {16'hFE40, 8'h0F, 1'b1, 1'b1}, {16'h8000, 8'h00, 1'b1, 1'b0},
    {16'h2000, 8'h11, 1'b0, 1'b1}, {16'h2000, 8'h11, 1'b0, 1'b1},
    {16'h2000, 8'h11, 1'b1, 1'b1}};

  initial begin
    // reset held while phi0 toggles
    repeat (3) @(negedge bbc_ck8);
    chk_bus("rst", 16'h8000, 8'h00, 1'b1, 1'b0);
    chk("rst_busy", bus_busy, 0);
    chk("rst_full", wr_full, 0);
    chk("rst_empty", wr_empty, 1);
    chk("rst_ovf", wr_overflow, 0);
    repeat (4) @(negedge bbc_ck8);
    chk("rst_addr_late", bus_addr, 16'h8000);
    nxt();
    resetb = 1'b1;

    // rises with an empty FIFO leave the dummy read in place
    repeat (6) nxt();
    chk_bus("idle", 16'h8000, 8'h00, 1'b1, 1'b0);
    chk("idle_nolog", log_addr.size(), 0);

    // single normal write
    align(2'd0);
    wr_req = 1'b1; wr_addr = 16'h3000; wr_data = 8'h5A;
    nxt(); wr_req = 1'b0;
    chk_bus("s_c1", 16'h8000, 8'h00, 1'b1, 1'b0);
    chk("s_empty_lo", wr_empty, 0);
    nxt(); chk_bus("s_c2", 16'h8000, 8'h00, 1'b1, 1'b0);
    nxt(); chk_bus("s_drv0", 16'h3000, 8'h5A, 1'b0, 1'b1);
    nxt(); chk_bus("s_drv1", 16'h3000, 8'h5A, 1'b0, 1'b1);
    nxt(); chk_bus("s_hold", 16'h3000, 8'h5A, 1'b1, 1'b1);
    nxt(); chk_bus("s_done", 16'h8000, 8'h00, 1'b1, 1'b0);
    chk("s_empty_hi", wr_empty, 1);
    chk("s_logn", log_addr.size(), 1);
    chk("s_log_addr", log_addr[0], 16'h3000);
    chk("s_log_data", log_data[0], 8'h5A);

    // four back-to-back pushes, then a fifth while full with no pop
    base = log_addr.size();
    align(2'd0);
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 16'h1000 + 16'(i); wr_data = 8'hA0 + 8'(i);
      nxt();
    end
    wr_addr = 16'h1004; wr_data = 8'hE5;
    @(negedge bbc_ck8);
    chk("b_full", wr_full, 1);
    chk("b_ovf_pre", wr_overflow, 0);
    nxt(); wr_req = 1'b0;
    @(negedge bbc_ck8);
    chk("b_ovf", wr_overflow, 1);
    chk("b_full_hold", wr_full, 1);
    nxt();
    @(negedge bbc_ck8);
    chk("b_full_clr", wr_full, 0);
    wait_empty(100);
    chk("b_logn", log_addr.size(), base + 4);
    if (log_addr.size() == base + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("b_addr", log_addr[base+i], 16'h1000 + 16'(i));
        chk("b_data", log_data[base+i], 8'hA0 + 8'(i));
        if (i > 0) chk("b_slot_gap", log_cyc[base+i] - log_cyc[base+i-1], 4);
      end
    end

    // stretched 1 MHz write, then a normal one on the third rise
    base = log_addr.size();
    align(2'd0);
    wr_req = 1'b1; wr_addr = 16'hFE40; wr_data = 8'h0F;
    nxt();
    wr_addr = 16'h2000; wr_data = 8'h11;
    for (int k = 0; k < 13; k++) begin
      if (k == 1) wr_req = 1'b0;
      chk_bus($sformatf("st%0d", k), str_tab[k][25:10], str_tab[k][9:2], str_tab[k][1], str_tab[k][0]);
      nxt();
    end
    @(negedge bbc_ck8);
    chk("st_empty", wr_empty, 1);
    chk("st_logn", log_addr.size(), base + 2);
    if (log_addr.size() == base + 2) begin
      chk("st_log0", log_addr[base], 16'hFE40);
      chk("st_log1", log_addr[base+1], 16'h2000);
    end

    // reset clears sticky overflow; then push on the HOLD pop while full
    nxt(); resetb = 1'b0;
    @(negedge bbc_ck8);
    chk("r_ovf_clr", wr_overflow, 0);
    nxt(); resetb = 1'b1;
    align(2'd0);
    for (int i = 0; i < 4; i++) begin
      wr_req = 1'b1; wr_addr = 16'h4000 + 16'(i); wr_data = 8'h10 + 8'(i);
      nxt();
    end
    wr_req = 1'b0;
    @(negedge bbc_ck8);
    chk("p_full", wr_full, 1);
    nxt();
    wr_req = 1'b1; wr_addr = 16'h4004; wr_data = 8'h14;
    chk_bus("p_hold", 16'h4000, 8'h10, 1'b1, 1'b1);
    nxt(); wr_req = 1'b0;
    @(negedge bbc_ck8);
    chk("p_full_kept", wr_full, 1);
    chk("p_no_ovf", wr_overflow, 0);
    nxt();
    chk_bus("p_drv", 16'h4001, 8'h11, 1'b0, 1'b1);
    #1 resetb = 1'b0;
    #1;
    chk("m_addr", bus_addr, 16'h8000);
    chk("m_rnw", bus_rnw, 1);
    chk("m_oe", bus_data_oe, 0);
    chk("m_empty", wr_empty, 1);
    chk("m_full", wr_full, 0);
    nxt(); nxt(); resetb = 1'b1;
    repeat (6) nxt();
    chk_bus("m_discard", 16'h8000, 8'h00, 1'b1, 1'b0);
    chk("m_discard_empty", wr_empty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/bbc_wrbuf_m.md
# bbc_wrbuf_m

Posted-write buffer between the high-speed CPU side of the accelerator and the 2 MHz BBC host bus. It accepts lomem write transactions (address + data) from the CPU at any CPU clock rate, queues them in a small FIFO, and drains them onto the host bus one per BBC 2 MHz slot. Slots are aligned to bbc_ck2_phi0. The CPU therefore only stalls when the buffer is full or when a host read must wait for pending writes to retire. Between slots the block drives a harmless dummy host read of 0x8000 (paged ROM).

## Interface
- DEPTH, 4: FIFO entries, power of two, 2..16.
- STRETCH_LO, 16'hFC00: first address of the 1 MHz (FRED/JIM/SHEILA) region.
- STRETCH_HI, 16'hFEFF: last address of the 1 MHz region.

- bbc_ck8  in  1  8 MHz host clock; every flop in the block is clocked on its rising edge.
- resetb  in  1  reset, asynchronous, active-low.
- bbc_ck2_phi0  in  1  host 2 MHz phase, 2 ck8 cycles low then 2 high; treated as a synchronous input.
- wr_req  in  1  single-ck8-cycle push strobe.
- wr_addr  in  16  host write address.
- wr_data  in  8  host write data.
- wr_full  out  1  count == DEPTH; integration drives CPU rdy low.
- wr_empty  out  1  count == 0 and bus FSM in IDLE; host reads must wait for this.
- wr_overflow  out  1  sticky; set by a push that was dropped; cleared only by reset.
- bus_addr  out  16  host address.
- bus_data  out  8  host write data.
- bus_data_oe  out  1  enable for the bbc_data drivers.
- bus_rnw  out  1  host read/not-write.
- bus_busy  out  1  FSM not in IDLE.

## Operation
- FIFO: circular, rd_ptr/wr_ptr of log2(DEPTH) bits, wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Push is accepted when wr_req & (count < DEPTH | pop this cycle).
- Push with count == DEPTH and no pop: entry dropped, wr_overflow set.
- Simultaneous push and pop: count unchanged and both pointers advance.
- phi0_q is phi0 registered once. rise = phi0 & !phi0_q; fall = !phi0 & phi0_q.
- Each entry carries a stretch flag: STRETCH_LO <= addr <= STRETCH_HI, computed at push.
- FSM states:
  - IDLE: bus shows the dummy read. On rise with count != 0 -> DRIVE, with bus_addr and bus_data loaded from the head entry; slots = stretch ? 2 : 1.
  - DRIVE: bus_rnw = 0, bus_data_oe = 1. On fall: slots decrements. If the result is 0 -> HOLD; else -> WAIT.
  - WAIT (stretched only): bus_rnw = 1, bus_data_oe = 1, address held. On rise -> DRIVE.
  - HOLD: exactly one ck8 cycle with bus_rnw = 1, bus_data_oe = 1, address and data held (data hold after the write). Pop on exit. -> IDLE.
- A rise arriving in the HOLD cycle cannot start a slot. The next entry uses the next rise, so the sustained rate is 1 write per 2 MHz slot.
- IDLE/dummy bus values: bus_addr = 16'h8000, bus_data = 8'h00, bus_rnw = 1, bus_data_oe = 0.

## Timing
- All outputs reset to: bus_addr 16'h8000, bus_data 0, bus_rnw 1, bus_data_oe 0, bus_busy 0, wr_full 0, wr_empty 1, wr_overflow 0. Pointers, count, phi0_q and slots reset to 0; FSM resets to IDLE.
- Push to visible: wr_full and count update one ck8 after the wr_req cycle.
- Minimum push-to-bus latency: push registered at edge N; rise seen at edge N+1 -> DRIVE from N+2.
- Normal write: DRIVE lasts the 2 high-phase ck8 cycles, then HOLD for 1 cycle.
- Write pulse: bus_rnw is low only while phi0 is high, delayed by one ck8 of registration.
- Stretched write: DRIVE, then WAIT for 2 cycles, then DRIVE again, then HOLD (two host slots).
- wr_empty rises in the cycle after the HOLD exit.
- Reset mid-write: bus signals return to dummy values asynchronously and all queued entries are discarded.
- bus_data_oe must never be 1 while bus_rnw = 1 outside the WAIT and HOLD states.

## Test plan
- Reset with phi0 toggling: all outputs hold their reset values. First rise after reset with an empty FIFO: bus stays 8000 / rnw 1.
- Single push (3000, 5A):
  - next rise -> bus_addr 3000, bus_data 5A, rnw low for 2 cycles, oe high for 3 cycles.
  - wr_empty returns to 1 afterwards.
  - Exactly one host write is logged.
- 4 back-to-back pushes (DEPTH 4, one per ck8):
  - wr_full = 1 after the 4th push.
  - Writes appear on 4 consecutive slots in order, and wr_full clears after the first pop.
- Fifth push while full with no pop: dropped, wr_overflow = 1; the remaining 4 entries drain intact.
- Push (FE40, 0F):
  - rnw low across two phi0 high phases, with the address held through WAIT.
  - Followed by push (2000, 11), which starts only on the third rise.
- Push in the same cycle as the HOLD pop while full: accepted, count stays 4, wr_overflow stays 0. Then assert resetb low mid-DRIVE: bus returns to 8000 immediately and wr_empty = 1.
